// File: rtl/l2_req_ctrl.sv
// Request/response front end for the single-port 64-bit L2 memory wrapper.
// Grants are throttled by free response-FIFO space so read data is never dropped.
module l2_req_ctrl #(
    parameter int MEM_ADDR_WIDTH = 15,
    parameter int ADDR_WIDTH     = 32,
    parameter int RESP_DEPTH     = 2
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic [ADDR_WIDTH-1:0]     add_i,
    input  logic                      wen_i,
    input  logic [63:0]               wdata_i,
    input  logic [7:0]                be_i,
    output logic                      r_valid_o,
    input  logic                      r_ready_i,
    output logic [63:0]               r_rdata_o,
    output logic                      r_opc_o,
    output logic                      r_err_o,
    output logic                      mem_cen_o,
    output logic                      mem_wen_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_a_o,
    output logic [63:0]               mem_d_o,
    output logic [7:0]                mem_be_o,
    input  logic [63:0]               mem_q_i
);

    localparam int PW = $clog2(RESP_DEPTH);
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int SW = CW + 1;

    typedef struct packed {
        logic [63:0] rdata;
        logic        opc;
        logic        err;
    } resp_t;

    logic          inflight_q, inflight_d;
    logic          is_read_q, is_read_d;
    logic          err_q, err_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    resp_t         fifo_q [RESP_DEPTH];

    logic          oor;
    logic          push;
    logic          pop;
    logic [SW-1:0] space;
    resp_t         push_entry;
    resp_t         head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign oor  = |add_i[ADDR_WIDTH-1:MEM_ADDR_WIDTH+3];
    assign push = inflight_q;
    assign pop  = r_valid_o & r_ready_i;

    // Counting the in-flight slot and crediting a same-cycle pop keeps
    // count + inflight <= RESP_DEPTH while still allowing one grant per cycle.
    assign space = SW'(RESP_DEPTH) - SW'(count_q) - SW'(inflight_q) + SW'(pop);

    assign gnt_o     = RSTN & req_i & (space != '0);
    assign mem_cen_o = ~(gnt_o & ~oor);
    assign mem_wen_o = ~(gnt_o & ~oor & ~wen_i);
    assign mem_a_o   = add_i[MEM_ADDR_WIDTH+2:3];
    assign mem_d_o   = wdata_i;
    assign mem_be_o  = be_i;

    assign head      = fifo_q[rd_ptr_q];
    assign r_valid_o = (count_q != '0);
    assign r_rdata_o = head.rdata;
    assign r_opc_o   = head.opc;
    assign r_err_o   = head.err;

    always_comb begin
        inflight_d       = gnt_o;
        is_read_d        = is_read_q;
        err_d            = err_q;
        count_d          = count_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        push_entry.rdata = (is_read_q & ~err_q) ? mem_q_i : 64'h0;
        push_entry.opc   = is_read_q;
        push_entry.err   = err_q;

        if (gnt_o) begin
            is_read_d = wen_i;
            err_d     = oor;
        end
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            inflight_q <= 1'b0;
            is_read_q  <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            inflight_q <= inflight_d;
            is_read_q  <= is_read_d;
            err_q      <= err_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage is left unreset; entries only become visible through count_q.
    always_ff @(posedge CLK) begin
        if (RSTN && push) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: tb/tb_l2_req_ctrl.sv
// Directed bench for l2_req_ctrl with a behavioural one-cycle-latency SRAM
// and an in-order response scoreboard.
module tb_l2_req_ctrl;

    localparam int MAW   = 15;
    localparam int AW    = 32;
    localparam int DEPTH = 2;

    logic           CLK = 1'b0;
    logic           RSTN;
    logic           req_i;
    logic           gnt_o;
    logic [AW-1:0]  add_i;
    logic           wen_i;
    logic [63:0]    wdata_i;
    logic [7:0]     be_i;
    logic           r_valid_o;
    logic           r_ready_i;
    logic [63:0]    r_rdata_o;
    logic           r_opc_o;
    logic           r_err_o;
    logic           mem_cen_o;
    logic           mem_wen_o;
    logic [MAW-1:0] mem_a_o;
    logic [63:0]    mem_d_o;
    logic [7:0]     mem_be_o;
    logic [63:0]    mem_q_i = 64'h0;

    int errors = 0;
    int checks = 0;
    int out_cnt = 0;
    logic [65:0] exp_q[$];
    logic [63:0] mem [int];

    l2_req_ctrl #(.MEM_ADDR_WIDTH(MAW), .ADDR_WIDTH(AW), .RESP_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RSTN(RSTN), .req_i(req_i), .gnt_o(gnt_o), .add_i(add_i),
        .wen_i(wen_i), .wdata_i(wdata_i), .be_i(be_i), .r_valid_o(r_valid_o),
        .r_ready_i(r_ready_i), .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o),
        .r_err_o(r_err_o), .mem_cen_o(mem_cen_o), .mem_wen_o(mem_wen_o),
        .mem_a_o(mem_a_o), .mem_d_o(mem_d_o), .mem_be_o(mem_be_o), .mem_q_i(mem_q_i)
    );

    always #5 CLK = ~CLK;

    function automatic logic [63:0] init_word(input int a);
        return 64'hA5A5_0000_0000_0000 | 64'(a);
    endfunction

    // Behavioural SRAM: unwritten words read back as init_word(address).
    always @(posedge CLK) begin
        logic [63:0] cur;
        int a;
        a = int'(mem_a_o);
        cur = mem.exists(a) ? mem[a] : init_word(a);
        if (!mem_cen_o) begin
            if (!mem_wen_o) begin
                for (int b = 0; b < 8; b++) begin
                    if (mem_be_o[b]) cur[b*8 +: 8] = mem_d_o[b*8 +: 8];
                end
                mem[a] = cur;
            end else begin
                mem_q_i <= cur;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic to_neg();
        @(negedge CLK);
    endtask

    task automatic to_next();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input logic r, input logic [AW-1:0] a, input logic w,
                           input logic [63:0] d, input logic [7:0] b);
        req_i   = r;
        add_i   = a;
        wen_i   = w;
        wdata_i = d;
        be_i    = b;
    endtask

    // Response scoreboard and outstanding-request bound.
    always @(negedge CLK) begin
        logic [65:0] e;
        if (!RSTN) begin
            out_cnt = 0;
        end else begin
            checks++;
            assert (out_cnt <= DEPTH) else begin
                errors++;
                $error("FAIL overflow: observed=%0d expected<=%0d", out_cnt, DEPTH);
            end
            if (r_valid_o && r_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_resp: observed=%h expected=none", r_rdata_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_opc", 64'(r_opc_o), 64'(e[65]));
                    chk("resp_err", 64'(r_err_o), 64'(e[64]));
                    chk("resp_rdata", r_rdata_o, e[63:0]);
                end
            end
            out_cnt = out_cnt + int'(gnt_o) - int'(r_valid_o & r_ready_i);
        end
    end

    initial begin
        logic [5:0] full_gnt;
        int idx;
        RSTN = 1'b0;
        r_ready_i = 1'b1;
        set_req(1'b1, 32'h40, 1'b1, 64'h0, 8'hFF);
        repeat (2) begin
            to_neg();
            chk("rst_gnt", 64'(gnt_o), 64'd0);
            chk("rst_cen", 64'(mem_cen_o), 64'd1);
            chk("rst_wen", 64'(mem_wen_o), 64'd1);
            chk("rst_valid", 64'(r_valid_o), 64'd0);
            to_next();
        end
        RSTN = 1'b1;
        req_i = 1'b0;
        to_neg();
        chk("idle_gnt", 64'(gnt_o), 64'd0);
        chk("idle_valid", 64'(r_valid_o), 64'd0);
        to_next();

        // Full write then read of word 8.
        set_req(1'b1, 32'h40, 1'b0, 64'h1122334455667788, 8'hFF);
        to_neg();
        chk("wr_gnt", 64'(gnt_o), 64'd1);
        chk("wr_cen", 64'(mem_cen_o), 64'd0);
        chk("wr_wen", 64'(mem_wen_o), 64'd0);
        chk("wr_a", 64'(mem_a_o), 64'd8);
        chk("wr_d", mem_d_o, 64'h1122334455667788);
        chk("wr_be", 64'(mem_be_o), 64'hFF);
        exp_q.push_back({1'b0, 1'b0, 64'h0});
        to_next();
        set_req(1'b1, 32'h40, 1'b1, 64'h0, 8'hFF);
        to_neg();
        chk("rd_gnt", 64'(gnt_o), 64'd1);
        chk("rd_cen", 64'(mem_cen_o), 64'd0);
        chk("rd_wen", 64'(mem_wen_o), 64'd1);
        chk("rd_a", 64'(mem_a_o), 64'd8);
        exp_q.push_back({1'b1, 1'b0, 64'h1122334455667788});
        to_next();
        req_i = 1'b0;
        to_neg();
        chk("wresp_valid", 64'(r_valid_o), 64'd1);
        chk("wresp_opc", 64'(r_opc_o), 64'd0);
        chk("wresp_rdata", r_rdata_o, 64'h0);
        to_next();
        to_neg();
        chk("rresp_valid", 64'(r_valid_o), 64'd1);
        chk("rresp_opc", 64'(r_opc_o), 64'd1);
        chk("rresp_rdata", r_rdata_o, 64'h1122334455667788);
        to_next();
        to_neg();
        chk("rresp_done", 64'(r_valid_o), 64'd0);
        to_next();

        // Partial write over word 8, then readback.
        set_req(1'b1, 32'h40, 1'b0, 64'hAAAAAAAABBBBBBBB, 8'h0F);
        to_neg();
        chk("pw_gnt", 64'(gnt_o), 64'd1);
        chk("pw_be", 64'(mem_be_o), 64'h0F);
        exp_q.push_back({1'b0, 1'b0, 64'h0});
        to_next();
        set_req(1'b1, 32'h40, 1'b1, 64'h0, 8'hFF);
        to_neg();
        chk("pr_gnt", 64'(gnt_o), 64'd1);
        exp_q.push_back({1'b1, 1'b0, 64'h11223344BBBBBBBB});
        to_next();
        req_i = 1'b0;
        repeat (4) begin to_neg(); to_next(); end

        // Eight back-to-back reads of words 0..7.
        for (int k = 0; k < 10; k++) begin
            if (k < 8) set_req(1'b1, AW'(k * 8), 1'b1, 64'h0, 8'hFF);
            else req_i = 1'b0;
            to_neg();
            if (k < 8) begin
                chk("burst_gnt", 64'(gnt_o), 64'd1);
                exp_q.push_back({1'b1, 1'b0, init_word(k)});
            end
            chk("burst_valid", 64'(r_valid_o), (k >= 2) ? 64'd1 : 64'd0);
            to_next();
        end
        to_neg();
        to_next();

        // Backpressure: only DEPTH grants while r_ready_i is low.
        r_ready_i = 1'b0;
        full_gnt = 6'b000011;
        idx = 0;
        for (int k = 0; k < 6; k++) begin
            set_req(1'b1, AW'((idx + 1) * 8), 1'b1, 64'h0, 8'hFF);
            to_neg();
            chk("full_gnt", 64'(gnt_o), 64'(full_gnt[k]));
            chk("full_valid", 64'(r_valid_o), (k >= 2) ? 64'd1 : 64'd0);
            if (full_gnt[k]) begin
                exp_q.push_back({1'b1, 1'b0, init_word(idx + 1)});
                idx++;
            end
            to_next();
        end
        r_ready_i = 1'b1;
        set_req(1'b1, AW'((idx + 1) * 8), 1'b1, 64'h0, 8'hFF);
        to_neg();
        chk("release_gnt", 64'(gnt_o), 64'd1);
        chk("release_valid", 64'(r_valid_o), 64'd1);
        exp_q.push_back({1'b1, 1'b0, init_word(idx + 1)});
        to_next();
        req_i = 1'b0;
        repeat (4) begin to_neg(); to_next(); end

        // Out-of-range read never touches memory.
        set_req(1'b1, 32'h0004_0000, 1'b1, 64'h0, 8'hFF);
        to_neg();
        chk("oor_gnt", 64'(gnt_o), 64'd1);
        chk("oor_cen", 64'(mem_cen_o), 64'd1);
        chk("oor_wen", 64'(mem_wen_o), 64'd1);
        exp_q.push_back({1'b1, 1'b1, 64'h0});
        to_next();
        req_i = 1'b0;
        to_neg();
        chk("oor_valid_n1", 64'(r_valid_o), 64'd0);
        to_next();
        to_neg();
        chk("oor_valid", 64'(r_valid_o), 64'd1);
        chk("oor_err", 64'(r_err_o), 64'd1);
        chk("oor_rdata", r_rdata_o, 64'h0);
        to_next();
        repeat (2) begin to_neg(); to_next(); end

        // Reset with one response queued and one in flight.
        r_ready_i = 1'b0;
        set_req(1'b1, 32'h20, 1'b1, 64'h0, 8'hFF);
        to_neg();
        chk("mid_gnt0", 64'(gnt_o), 64'd1);
        to_next();
        set_req(1'b1, 32'h28, 1'b1, 64'h0, 8'hFF);
        to_neg();
        chk("mid_gnt1", 64'(gnt_o), 64'd1);
        to_next();
        req_i = 1'b0;
        RSTN = 1'b0;
        to_neg();
        to_next();
        RSTN = 1'b1;
        r_ready_i = 1'b1;
        repeat (3) begin
            to_neg();
            chk("post_rst_valid", 64'(r_valid_o), 64'd0);
            to_next();
        end

        // Fresh read after reset sees the partially written word.
        set_req(1'b1, 32'h40, 1'b1, 64'h0, 8'hFF);
        to_neg();
        chk("fresh_gnt", 64'(gnt_o), 64'd1);
        exp_q.push_back({1'b1, 1'b0, 64'h11223344BBBBBBBB});
        to_next();
        req_i = 1'b0;
        to_neg();
        to_next();
        to_neg();
        chk("fresh_valid", 64'(r_valid_o), 64'd1);
        chk("fresh_rdata", r_rdata_o, 64'h11223344BBBBBBBB);
        to_next();
        repeat (2) begin to_neg(); to_next(); end

        chk("drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
